// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and helpers for the up/down PWM with dead time:
//               dead-time state encoding and duty clipping.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Dead-time FSM states: both low, high side on, low side on, gap
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DEAD = 2'd3
    } dt_state_t;

    // Saturate a requested duty to the counter modulus
    function automatic logic [31:0] clip_duty(input logic [31:0] i_duty,
                                              input logic [31:0] i_max);
        return (i_duty > i_max) ? i_max : i_duty;
    endfunction

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_deadtime.sv
`default_nettype none
// ============================================================================
// Module      : pwm_deadtime
// Description : Turns a raw PWM level into complementary high/low drives with
//               a programmable gap in which both sides are off.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            raw,
    input  logic            en,
    input  logic [DT_W-1:0] dt,
    output logic            pwm_h,
    output logic            pwm_l
);

    dt_state_t       r_state;
    dt_state_t       w_state_nx;
    logic            r_target;
    logic            w_target_nx;
    logic [DT_W-1:0] r_cnt;
    logic [DT_W-1:0] w_cnt_nx;
    logic            w_load;
    logic            r_pwm_h;
    logic            r_pwm_l;

    // Next-state logic: a side change always passes through DEAD unless dt is 0
    always_comb begin
        w_state_nx  = r_state;
        w_target_nx = r_target;
        w_cnt_nx    = r_cnt;
        w_load      = 1'b0;

        if (!en) begin
            w_state_nx = IDLE;
        end else begin
            case (r_state)
                IDLE: w_load = 1'b1;
                HIGH: w_load = !raw;
                LOW:  w_load = raw;
                DEAD: begin
                    if (raw != r_target) begin
                        w_load = 1'b1;
                    end else if (r_cnt == '0) begin
                        w_state_nx = r_target ? HIGH : LOW;
                    end else begin
                        w_cnt_nx = r_cnt - DT_W'(1);
                    end
                end
                default: w_state_nx = IDLE;
            endcase

            // Head toward the side that raw now asks for; dt is sampled here only
            if (w_load) begin
                w_target_nx = raw;
                if (dt == '0) begin
                    w_state_nx = raw ? HIGH : LOW;
                end else begin
                    w_state_nx = DEAD;
                    w_cnt_nx   = dt - DT_W'(1);
                end
            end
        end
    end

    // State, target and gap counter; drives are flopped from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_target <= 1'b0;
            r_cnt    <= '0;
            r_pwm_h  <= 1'b0;
            r_pwm_l  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_target <= w_target_nx;
            r_cnt    <= w_cnt_nx;
            r_pwm_h  <= (w_state_nx == HIGH);
            r_pwm_l  <= (w_state_nx == LOW);
        end
    end

    assign pwm_h = r_pwm_h;
    assign pwm_l = r_pwm_l;

endmodule : pwm_deadtime
`default_nettype wire

// File: rtl/updown_pwm_dt.sv
`default_nettype none
// ============================================================================
// Module      : updown_pwm_dt
// Description : PWM generator fed by an external mod-N up/down counter.
//               Double-buffered duty, period boundary detection, compare,
//               and complementary outputs with dead time.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_pwm_dt
    import pwm_pkg::*;
#(
    parameter int N    = 10,
    parameter int DT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [$clog2(N)-1:0] q,
    input  logic [$clog2(N):0]   duty_in,
    input  logic                 duty_wr,
    input  logic [DT_W-1:0]      dt,
    output logic                 pwm_h,
    output logic                 pwm_l,
    output logic                 period_tick,
    output logic                 duty_pending
);

    localparam int QW = $clog2(N);
    localparam int DW = QW + 1;
    localparam logic [QW-1:0] c_Q_LAST = QW'(N - 1);

    logic          w_bnd;
    logic          w_raw;
    logic [DW-1:0] w_duty_clip;
    logic [DW-1:0] r_duty_act;
    logic [DW-1:0] r_duty_pend;
    logic          r_pend_flag;
    logic          r_period_tick;

    // Period starts at 0 when counting up and at N-1 when counting down
    assign w_bnd       = (mode && (q == '0)) || (!mode && (q == c_Q_LAST));
    assign w_duty_clip = DW'(clip_duty(32'(duty_in), 32'(N)));
    assign w_raw       = ({1'b0, q} < r_duty_act);

    // Duty double buffer: new writes wait in pending until a period boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_act    <= '0;
            r_duty_pend   <= '0;
            r_pend_flag   <= 1'b0;
            r_period_tick <= 1'b0;
        end else begin
            r_period_tick <= w_bnd;
            if (w_bnd && r_pend_flag) begin
                r_duty_act <= r_duty_pend;
            end
            if (duty_wr) begin
                r_duty_pend <= w_duty_clip;
                r_pend_flag <= 1'b1;
            end else if (w_bnd) begin
                r_pend_flag <= 1'b0;
            end
        end
    end

    assign period_tick  = r_period_tick;
    assign duty_pending = r_pend_flag;

    pwm_deadtime #(
        .DT_W (DT_W)
    ) u_deadtime (
        .clk   (clk),
        .rst   (rst),
        .raw   (w_raw),
        .en    (en),
        .dt    (dt),
        .pwm_h (pwm_h),
        .pwm_l (pwm_l)
    );

endmodule : updown_pwm_dt
`default_nettype wire

// File: tb/tb_updown_pwm_dt.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_pwm_dt
// Description : Self-checking bench for updown_pwm_dt (N=10, DT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_pwm_dt;

    localparam int N = 10;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [3:0] q;
    logic [4:0] duty_in;
    logic       duty_wr;
    logic [3:0] dt;
    logic       pwm_h;
    logic       pwm_l;
    logic       period_tick;
    logic       duty_pending;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (behavioural, from the rules)
    int m_act, m_pend, m_run;
    bit m_flag, m_tick, m_h, m_l, m_rawprev;

    typedef struct packed {
        logic       en;
        logic       mode;
        logic [3:0] q;
        logic [4:0] din;
        logic       wr;
        logic [3:0] dt;
        logic       h;
        logic       l;
        logic       tick;
        logic       pend;
    } vec_t;

    vec_t tbl[24];

    updown_pwm_dt #(
        .N    (10),
        .DT_W (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .q            (q),
        .duty_in      (duty_in),
        .duty_wr      (duty_wr),
        .dt           (dt),
        .pwm_h        (pwm_h),
        .pwm_l        (pwm_l),
        .period_tick  (period_tick),
        .duty_pending (duty_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_pend = 0; m_run = 0;
        m_flag = 0; m_tick = 0; m_h = 0; m_l = 0; m_rawprev = 0;
    endtask

    // Output side after the edge = raw, once en and raw have held for dt+1 cycles
    task automatic model_step();
        bit bnd, raw;
        bnd = mode ? (int'(q) == 0) : (int'(q) == N - 1);
        raw = int'(q) < m_act;
        if (!en) m_run = 0;
        else if (m_run > 0 && raw == m_rawprev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else m_run = 1;
        m_rawprev = raw;
        m_h = en && (m_run >= int'(dt) + 1) && raw;
        m_l = en && (m_run >= int'(dt) + 1) && !raw;
        if (bnd && m_flag) m_act = m_pend;
        if (duty_wr) begin
            m_pend = (int'(duty_in) > N) ? N : int'(duty_in);
            m_flag = 1;
        end else if (bnd) begin
            m_flag = 0;
        end
        m_tick = bnd;
    endtask

    task automatic cyc(input bit cmp);
        model_step();
        @(posedge clk);
        #1;
        if (cmp) begin
            chk("pwm_h", int'(pwm_h), int'(m_h));
            chk("pwm_l", int'(pwm_l), int'(m_l));
            chk("period_tick", int'(period_tick), int'(m_tick));
            chk("duty_pending", int'(duty_pending), int'(m_flag));
            chk("both_high", int'(pwm_h & pwm_l), 0);
        end
    endtask

    task automatic adv();
        if (mode) q = (q == 4'd9) ? 4'd0 : q + 4'd1;
        else      q = (q == 4'd0) ? 4'd9 : q - 4'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; duty_wr = 1'b0; duty_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pwm_h", int'(pwm_h), 0);
        chk("rst_pwm_l", int'(pwm_l), 0);
        chk("rst_tick", int'(period_tick), 0);
        chk("rst_pending", int'(duty_pending), 0);
        rst = 1'b0;
    endtask

    // One period window: ten counter steps ending on the boundary step
    task automatic run_period(input int wq, input int wv, input int wq2, input int wv2,
                              output int hc, output int lc, output int pend_wr,
                              output int tick_end, output int pend_end);
        hc = 0; lc = 0; pend_wr = -1; tick_end = 0; pend_end = 0;
        for (int k = 0; k < 10; k++) begin
            adv();
            if (int'(q) == wq)  begin duty_in = 5'(wv);  duty_wr = 1'b1; end
            if (int'(q) == wq2) begin duty_in = 5'(wv2); duty_wr = 1'b1; end
            cyc(1'b1);
            if (duty_wr) pend_wr = int'(duty_pending);
            duty_wr = 1'b0;
            hc += int'(pwm_h);
            lc += int'(pwm_l);
            if (k == 9) begin
                tick_end = int'(period_tick);
                pend_end = int'(duty_pending);
            end
        end
    endtask

    initial begin
        int hc, lc, pw, te, pe, cz, ct;
        rst = 1'b1; en = 1'b0; mode = 1'b1; q = '0; duty_in = '0; duty_wr = 1'b0; dt = '0;

        // ---------------- table: en mode q din wr dt | h l tick pend
        tbl[0]  = {1'b1,1'b1,4'd5,5'd3, 1'b1,4'd0, 1'b0,1'b1,1'b0,1'b1};
        tbl[1]  = {1'b1,1'b1,4'd6,5'd3, 1'b0,4'd0, 1'b0,1'b1,1'b0,1'b1};
        tbl[2]  = {1'b1,1'b1,4'd7,5'd3, 1'b0,4'd0, 1'b0,1'b1,1'b0,1'b1};
        tbl[3]  = {1'b1,1'b1,4'd8,5'd3, 1'b0,4'd0, 1'b0,1'b1,1'b0,1'b1};
        tbl[4]  = {1'b1,1'b1,4'd9,5'd3, 1'b0,4'd0, 1'b0,1'b1,1'b0,1'b1};
        tbl[5]  = {1'b1,1'b1,4'd0,5'd3, 1'b0,4'd0, 1'b0,1'b1,1'b1,1'b0};
        tbl[6]  = {1'b1,1'b1,4'd1,5'd3, 1'b0,4'd0, 1'b1,1'b0,1'b0,1'b0};
        tbl[7]  = {1'b1,1'b1,4'd2,5'd3, 1'b0,4'd0, 1'b1,1'b0,1'b0,1'b0};
        tbl[8]  = {1'b1,1'b1,4'd3,5'd3, 1'b0,4'd0, 1'b0,1'b1,1'b0,1'b0};
        tbl[9]  = {1'b1,1'b1,4'd4,5'd3, 1'b0,4'd0, 1'b0,1'b1,1'b0,1'b0};
        tbl[10] = {1'b1,1'b1,4'd5,5'd15,1'b1,4'd0, 1'b0,1'b1,1'b0,1'b1};
        tbl[11] = {1'b1,1'b1,4'd6,5'd15,1'b0,4'd0, 1'b0,1'b1,1'b0,1'b1};
        tbl[12] = {1'b1,1'b1,4'd7,5'd15,1'b0,4'd0, 1'b0,1'b1,1'b0,1'b1};
        tbl[13] = {1'b1,1'b1,4'd8,5'd15,1'b0,4'd0, 1'b0,1'b1,1'b0,1'b1};
        tbl[14] = {1'b1,1'b1,4'd9,5'd15,1'b0,4'd0, 1'b0,1'b1,1'b0,1'b1};
        tbl[15] = {1'b1,1'b1,4'd0,5'd15,1'b0,4'd0, 1'b1,1'b0,1'b1,1'b0};
        tbl[16] = {1'b1,1'b1,4'd1,5'd15,1'b0,4'd0, 1'b1,1'b0,1'b0,1'b0};
        tbl[17] = {1'b1,1'b1,4'd9,5'd15,1'b0,4'd0, 1'b1,1'b0,1'b0,1'b0};
        tbl[18] = {1'b1,1'b1,4'd0,5'd15,1'b0,4'd2, 1'b1,1'b0,1'b1,1'b0};
        tbl[19] = {1'b0,1'b1,4'd1,5'd15,1'b0,4'd2, 1'b0,1'b0,1'b0,1'b0};
        tbl[20] = {1'b1,1'b1,4'd2,5'd15,1'b0,4'd2, 1'b0,1'b0,1'b0,1'b0};
        tbl[21] = {1'b1,1'b1,4'd3,5'd15,1'b0,4'd2, 1'b0,1'b0,1'b0,1'b0};
        tbl[22] = {1'b1,1'b1,4'd4,5'd15,1'b0,4'd2, 1'b1,1'b0,1'b0,1'b0};
        tbl[23] = {1'b1,1'b0,4'd9,5'd15,1'b0,4'd2, 1'b1,1'b0,1'b1,1'b0};

        do_reset();
        for (int i = 0; i < 24; i++) begin
            en = tbl[i].en; mode = tbl[i].mode; q = tbl[i].q;
            duty_in = tbl[i].din; duty_wr = tbl[i].wr; dt = tbl[i].dt;
            cyc(1'b0);
            chk($sformatf("tbl_h[%0d]", i), int'(pwm_h), int'(tbl[i].h));
            chk($sformatf("tbl_l[%0d]", i), int'(pwm_l), int'(tbl[i].l));
            chk($sformatf("tbl_tick[%0d]", i), int'(period_tick), int'(tbl[i].tick));
            chk($sformatf("tbl_pend[%0d]", i), int'(duty_pending), int'(tbl[i].pend));
        end
        duty_wr = 1'b0;

        // ---------------- dt=2, duty 3: 1 high, 5 low, 4 gap per period
        do_reset();
        en = 1'b1; mode = 1'b1; dt = 4'd2; q = 4'd1; duty_in = 5'd3; duty_wr = 1'b1;
        cyc(1'b1);
        duty_wr = 1'b0;
        for (int k = 0; k < 29; k++) begin adv(); cyc(1'b1); end
        hc = 0; lc = 0; cz = 0; ct = 0;
        for (int k = 0; k < 10; k++) begin
            adv(); cyc(1'b1);
            hc += int'(pwm_h); lc += int'(pwm_l);
            cz += int'(!pwm_h && !pwm_l); ct += int'(period_tick);
        end
        chk("dt2_high_cycles", hc, 1);
        chk("dt2_low_cycles", lc, 5);
        chk("dt2_gap_cycles", cz, 4);
        chk("dt2_ticks", ct, 1);

        // ---------------- duty buffering, dt=0
        do_reset();
        en = 1'b1; mode = 1'b1; dt = 4'd0; q = 4'd1; duty_in = 5'd3; duty_wr = 1'b1;
        cyc(1'b1);
        duty_wr = 1'b0;
        for (int k = 0; k < 9; k++) begin adv(); cyc(1'b1); end
        run_period(5, 7, -1, 0, hc, lc, pw, te, pe);
        chk("p1_high", hc, 3);
        chk("p1_pend_after_wr", pw, 1);
        chk("p1_tick_end", te, 1);
        chk("p1_pend_end", pe, 0);
        run_period(3, 4, 0, 2, hc, lc, pw, te, pe);
        chk("p2_high", hc, 7);
        chk("p2_pend_simul", pe, 1);
        run_period(-1, 0, -1, 0, hc, lc, pw, te, pe);
        chk("p3_high", hc, 4);
        chk("p3_pend_end", pe, 0);
        run_period(-1, 0, -1, 0, hc, lc, pw, te, pe);
        chk("p4_high", hc, 2);
        chk("p4_low", lc, 8);
        run_period(3, 15, -1, 0, hc, lc, pw, te, pe);
        chk("p5_high", hc, 2);
        run_period(3, 0, -1, 0, hc, lc, pw, te, pe);
        chk("clip15_high", hc, 10);
        chk("clip15_low", lc, 0);
        run_period(3, 31, -1, 0, hc, lc, pw, te, pe);
        chk("zero_high", hc, 0);
        chk("zero_low", lc, 10);
        run_period(-1, 0, -1, 0, hc, lc, pw, te, pe);
        chk("clip31_high", hc, 10);

        // ---------------- down mode, duty 3, dt=0
        do_reset();
        en = 1'b1; mode = 1'b0; dt = 4'd0; q = 4'd9; duty_in = 5'd3; duty_wr = 1'b1;
        cyc(1'b1);
        duty_wr = 1'b0;
        run_period(-1, 0, -1, 0, hc, lc, pw, te, pe);
        run_period(-1, 0, -1, 0, hc, lc, pw, te, pe);
        chk("down_high", hc, 3);
        chk("down_low", lc, 7);
        chk("down_tick_end", te, 1);

        // ---------------- narrow pulse swallowed: duty 1, dt=4
        do_reset();
        en = 1'b1; mode = 1'b1; dt = 4'd4; q = 4'd0; duty_in = 5'd1; duty_wr = 1'b1;
        cyc(1'b1);
        duty_wr = 1'b0;
        run_period(-1, 0, -1, 0, hc, lc, pw, te, pe);
        run_period(-1, 0, -1, 0, hc, lc, pw, te, pe);
        run_period(-1, 0, -1, 0, hc, lc, pw, te, pe);
        chk("narrow_high", hc, 0);
        chk("narrow_low", lc, 5);

        // ---------------- asynchronous reset while high
        do_reset();
        en = 1'b1; mode = 1'b1; dt = 4'd0; q = 4'd0; duty_in = 5'd10; duty_wr = 1'b1;
        cyc(1'b1);
        duty_wr = 1'b0;
        run_period(-1, 0, -1, 0, hc, lc, pw, te, pe);
        run_period(-1, 0, -1, 0, hc, lc, pw, te, pe);
        adv(); duty_in = 5'd4; duty_wr = 1'b1;
        cyc(1'b1);
        duty_wr = 1'b0;
        chk("pre_rst_high", int'(pwm_h), 1);
        chk("pre_rst_pend", int'(duty_pending), 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_h", int'(pwm_h), 0);
        chk("async_rst_l", int'(pwm_l), 0);
        chk("async_rst_pend", int'(duty_pending), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        hc = 0;
        for (int k = 0; k < 12; k++) begin adv(); cyc(1'b1); hc += int'(pwm_h); end
        chk("post_rst_high", hc, 0);

        // ---------------- randomized run against the model
        do_reset();
        q = 4'd0; mode = 1'b1; en = 1'b1; dt = 4'($urandom_range(0, 5));
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                en = 1'b0;
                dt = 4'($urandom_range(0, 6));
            end else begin
                en = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            end
            if ($urandom_range(0, 99) < 1) mode = ~mode;
            if ($urandom_range(0, 99) < 3) q = 4'($urandom_range(0, 9));
            else adv();
            duty_wr = ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0;
            duty_in = 5'($urandom_range(0, 31));
            cyc(1'b1);
        end
        duty_wr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_updown_pwm_dt
`default_nettype wire
